// File: rtl/spi1_initiator_pkg.sv
// Command encoding shared by the SPI1 initiator and spi1_controller.
package spi1_initiator_pkg;
    localparam int WB_ADDR_WIDTH = 20;
    localparam int DATA_WIDTH    = 8;
    localparam int TIMER_W       = 16;

    typedef enum logic [1:0] {
        OP_WRITE_AT   = 2'd0,
        OP_READ_AT    = 2'd1,
        OP_READ_NEXT  = 2'd2,
        OP_WRITE_NEXT = 2'd3
    } spi1_op_t;

    localparam logic [2:0] SPI1_OPCODE_WRITE_AT   = 3'b100;
    localparam logic [2:0] SPI1_OPCODE_READ_AT    = 3'b011;
    localparam logic [2:0] SPI1_OPCODE_READ_NEXT  = 3'b001;
    localparam logic [2:0] SPI1_OPCODE_WRITE_NEXT = 3'b010;

    // addr_hi is addr[19:16]; it rides in the low nibble of the command byte.
    function automatic logic [7:0] spi1_cmd_byte(input spi1_op_t op, input logic [3:0] addr_hi);
        logic [2:0] opc;
        case (op)
            OP_WRITE_AT:   opc = SPI1_OPCODE_WRITE_AT;
            OP_READ_AT:    opc = SPI1_OPCODE_READ_AT;
            OP_READ_NEXT:  opc = SPI1_OPCODE_READ_NEXT;
            default:       opc = SPI1_OPCODE_WRITE_NEXT;
        endcase
        return {opc, 1'b0, addr_hi};
    endfunction
endpackage

// File: rtl/spi1_initiator_shift_byte.sv
// One-byte mode-0 SCK generator and shifter: MSB first, SCK idle low,
// POCI captured on the cycle that raises SCK, done pulses after the 8th fall.
module spi1_initiator_shift_byte
    import spi1_initiator_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  poci,
    output logic                  done,
    output logic                  sck,
    output logic                  pico,
    output logic [DATA_WIDTH-1:0] rx_byte
);
    localparam int CW = $clog2(HALF_DIV);

    logic [CW-1:0]         cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_WIDTH-2:0] shreg;
    logic                  busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            pico    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rx_byte <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                sck     <= 1'b0;
                pico    <= tx_byte[DATA_WIDTH-1];
                shreg   <= tx_byte[DATA_WIDTH-2:0];
                cnt     <= CW'(HALF_DIV - 1);
                bit_cnt <= 3'd7;
            end else if (busy) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    cnt <= CW'(HALF_DIV - 1);
                    if (!sck) begin
                        sck     <= 1'b1;
                        rx_byte <= {rx_byte[DATA_WIDTH-2:0], poci};
                    end else begin
                        sck <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pico <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            pico    <= shreg[DATA_WIDTH-2];
                            shreg   <= {shreg[DATA_WIDTH-3:0], 1'b0};
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/spi1_initiator.sv
// SPI mode-0 initiator for spi1_controller: one command at a time, honours target stall.
// IDLE: ready, wait cmd | SETUP: CS low, first bit | SHIFT: command bytes | STALL: wait target
// RDBYTE: clock in read byte | FINISH: SCK low hold, raise CS, done | GAP: CS high spacing
module spi1_initiator
    import spi1_initiator_pkg::*;
#(
    parameter int unsigned SCK_HALF_DIV  = 4,
    parameter int unsigned CS_GAP        = 6,
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  spi1_op_t                 cmd_op_i,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]    cmd_data_i,
    output logic                     done_o,
    output logic                     error_o,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic                     spi_sck_o,
    output logic                     spi_cs_no,
    output logic                     spi_pico_o,
    input  logic                     spi_poci_i,
    input  logic                     spi_stall_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_STALL, S_RDBYTE, S_FINISH, S_GAP
    } state_t;

    state_t                state;
    logic [31:0]           frame;
    logic [2:0]            bytes_left;
    logic                  is_read;
    logic                  err_flag;
    logic [TIMER_W-1:0]    timer;
    logic [1:0]            settle;
    logic [1:0]            stall_sync;
    logic                  shift_start;
    logic                  shift_done;
    logic                  shift_pico;
    logic [DATA_WIDTH-1:0] shift_rx;
    logic [DATA_WIDTH-1:0] shift_tx;
    logic [7:0]            cmd_byte;

    assign cmd_byte   = spi1_cmd_byte(cmd_op_i, cmd_addr_i[19:16]);
    assign shift_tx   = (state == S_RDBYTE) ? '0 : frame[31:24];
    assign spi_pico_o = (state == S_SETUP) ? frame[31] : shift_pico;

    spi1_initiator_shift_byte #(.HALF_DIV(SCK_HALF_DIV)) u_shift (
        .clk     (clock_i),
        .rst     (reset_i),
        .start   (shift_start),
        .tx_byte (shift_tx),
        .poci    (spi_poci_i),
        .done    (shift_done),
        .sck     (spi_sck_o),
        .pico    (shift_pico),
        .rx_byte (shift_rx)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_sync  <= '0;
            state       <= S_GAP;
            timer       <= TIMER_W'(CS_GAP - 1);
            spi_cs_no   <= 1'b1;
            cmd_ready_o <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            rd_data_o   <= '0;
            frame       <= '0;
            bytes_left  <= '0;
            is_read     <= 1'b0;
            err_flag    <= 1'b0;
            settle      <= '0;
            shift_start <= 1'b0;
        end else begin
            stall_sync  <= {stall_sync[0], spi_stall_i};
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            shift_start <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    cmd_ready_o <= 1'b0;
                    spi_cs_no   <= 1'b0;
                    err_flag    <= 1'b0;
                    timer       <= TIMER_W'(SCK_HALF_DIV - 1);
                    state       <= S_SETUP;
                    // Frame is left-aligned so every byte goes out from frame[31:24].
                    case (cmd_op_i)
                        OP_WRITE_AT: begin
                            frame <= {cmd_byte, cmd_addr_i[15:0], cmd_data_i};
                            bytes_left <= 3'd4;
                            is_read <= 1'b0;
                        end
                        OP_READ_AT: begin
                            frame <= {cmd_byte, cmd_addr_i[15:0], 8'h00};
                            bytes_left <= 3'd3;
                            is_read <= 1'b1;
                        end
                        OP_WRITE_NEXT: begin
                            frame <= {cmd_byte, cmd_data_i, 16'h0000};
                            bytes_left <= 3'd2;
                            is_read <= 1'b0;
                        end
                        default: begin
                            frame <= {cmd_byte, 24'h000000};
                            bytes_left <= 3'd1;
                            is_read <= 1'b1;
                        end
                    endcase
                end
                S_SETUP: begin
                    if (timer == '0) begin
                        shift_start <= 1'b1;
                        state       <= S_SHIFT;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                S_SHIFT: if (shift_done) begin
                    if (bytes_left == 3'd1) begin
                        settle <= 2'd1;
                        timer  <= TIMER_W'(STALL_TIMEOUT);
                        state  <= S_STALL;
                    end else begin
                        frame       <= {frame[23:0], 8'h00};
                        bytes_left  <= bytes_left - 3'd1;
                        shift_start <= 1'b1;
                    end
                end
                S_STALL: begin
                    // settle covers the synchronizer delay for a stall raised at the last fall.
                    if (settle == '0 && !stall_sync[1]) begin
                        if (is_read) begin
                            shift_start <= 1'b1;
                            state       <= S_RDBYTE;
                        end else begin
                            timer <= TIMER_W'(SCK_HALF_DIV - 1);
                            state <= S_FINISH;
                        end
                    end else begin
                        if (settle != '0) settle <= settle - 2'd1;
                        if (timer == '0) begin
                            err_flag <= 1'b1;
                            timer    <= TIMER_W'(SCK_HALF_DIV - 1);
                            state    <= S_FINISH;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                end
                S_RDBYTE: if (shift_done) begin
                    rd_data_o <= shift_rx;
                    timer     <= TIMER_W'(SCK_HALF_DIV - 1);
                    state     <= S_FINISH;
                end
                S_FINISH: begin
                    if (timer == '0) begin
                        spi_cs_no <= 1'b1;
                        done_o    <= 1'b1;
                        error_o   <= err_flag;
                        timer     <= TIMER_W'(CS_GAP - 1);
                        state     <= S_GAP;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: begin
                    if (timer == '0) begin
                        cmd_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi1_initiator.sv
// Directed bench for spi1_initiator with a behavioural SPI1 target on the far side.
module tb_spi1_initiator;
    import spi1_initiator_pkg::*;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    spi1_op_t    cmd_op_i = OP_WRITE_AT;
    logic [19:0] cmd_addr_i = '0;
    logic [7:0]  cmd_data_i = '0;
    logic        done_o, error_o;
    logic [7:0]  rd_data_o;
    logic        spi_sck_o, spi_cs_no, spi_pico_o;
    logic        spi_poci_i = 1'b0;
    logic        spi_stall_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // target model state
    int          tgt_bits = 8;
    logic [7:0]  tgt_resp = '0;
    logic        tgt_hang = 1'b0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    int          rise_cnt = 0;
    logic [31:0] cap = '0;
    logic [7:0]  resp_sh = '0;
    int          stall_cnt = -1;
    int          fall_cyc = 0;

    // results of the last issued command
    logic        r_seen, r_err, r_cs;
    logic [7:0]  r_rdata;
    int          r_cyc;

    spi1_initiator #(.SCK_HALF_DIV(4), .CS_GAP(6), .STALL_TIMEOUT(63)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .done_o(done_o), .error_o(error_o), .rd_data_o(rd_data_o),
        .spi_sck_o(spi_sck_o), .spi_cs_no(spi_cs_no), .spi_pico_o(spi_pico_o),
        .spi_poci_i(spi_poci_i), .spi_stall_i(spi_stall_i)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    // Target: busy (stall) for the whole frame plus 10 clocks after the last
    // frame bit, then presents read data MSB first, changing on falling SCK.
    always @(negedge clock_i) begin
        prev_sck <= spi_sck_o;
        prev_cs  <= spi_cs_no;
        if (prev_cs && !spi_cs_no) begin
            rise_cnt    <= 0;
            cap         <= '0;
            spi_stall_i <= 1'b1;
            stall_cnt   <= -1;
        end else if (!prev_cs && spi_cs_no) begin
            spi_stall_i <= 1'b0;
            stall_cnt   <= -1;
        end else if (!spi_cs_no) begin
            if (spi_sck_o && !prev_sck) begin
                if (rise_cnt < tgt_bits) cap <= {cap[30:0], spi_pico_o};
                rise_cnt <= rise_cnt + 1;
            end else if (!spi_sck_o && prev_sck) begin
                if (rise_cnt == tgt_bits) begin
                    fall_cyc <= cyc;
                    if (!tgt_hang) stall_cnt <= 10;
                end else if (rise_cnt > tgt_bits) begin
                    spi_poci_i <= resp_sh[7];
                    resp_sh    <= {resp_sh[6:0], 1'b0};
                end
            end
            if (stall_cnt > 0) begin
                stall_cnt <= stall_cnt - 1;
            end else if (stall_cnt == 0) begin
                spi_stall_i <= 1'b0;
                spi_poci_i  <= tgt_resp[7];
                resp_sh     <= {tgt_resp[6:0], 1'b0};
                stall_cnt   <= -1;
            end
        end
    end

    task automatic issue(input spi1_op_t op, input logic [19:0] addr, input logic [7:0] data,
                         input int bits, input logic [7:0] resp, input logic hang, input logic poke);
        int n;
        n = 0;
        while (!cmd_ready_o && n < 200) begin @(negedge clock_i); n++; end
        tgt_bits = bits; tgt_resp = resp; tgt_hang = hang;
        cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = data; cmd_valid_i = 1'b1;
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        r_seen = 1'b0; r_err = 1'b0; r_cs = 1'b0; r_rdata = '0; r_cyc = 0;
        n = 0;
        while (!r_seen && n < 3000) begin
            if (poke && n == 20) begin
                cmd_valid_i = 1'b1; cmd_op_i = OP_READ_AT; cmd_addr_i = '1; cmd_data_i = 8'hFF;
            end else begin
                cmd_valid_i = 1'b0;
            end
            @(negedge clock_i);
            n++;
            if (done_o) begin
                r_seen = 1'b1; r_err = error_o; r_cs = spi_cs_no; r_rdata = rd_data_o; r_cyc = cyc;
            end
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset_i = 1'b1;
        repeat (3) @(negedge clock_i);
        checks++; if (spi_cs_no !== 1'b1) begin errors++; $display("FAIL reset.cs_n got %b want 1", spi_cs_no); end
        checks++; if (spi_sck_o !== 1'b0) begin errors++; $display("FAIL reset.sck got %b want 0", spi_sck_o); end
        checks++; if (spi_pico_o !== 1'b0) begin errors++; $display("FAIL reset.pico got %b want 0", spi_pico_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset.ready got %b want 0", cmd_ready_o); end
        checks++; if ({done_o, error_o} !== 2'b00) begin errors++; $display("FAIL reset.done_err got %b want 00", {done_o, error_o}); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset.rd_data got %h want 00", rd_data_o); end
        reset_i = 1'b0;
        n = 0;
        while (!cmd_ready_o && n < 50) begin @(negedge clock_i); n++; end
        checks++; if (n != 6) begin errors++; $display("FAIL reset.gap_to_ready got %0d want 6", n); end
    endtask

    task automatic test_write_at();
        issue(OP_WRITE_AT, 20'h00000, 8'h00, 32, 8'h00, 1'b0, 1'b0);
        checks++; if (r_seen !== 1'b1) begin errors++; $display("FAIL write_at.done got %b want 1", r_seen); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL write_at.error got %b want 0", r_err); end
        checks++; if (cap !== 32'h80000000) begin errors++; $display("FAIL write_at.frame got %h want 80000000", cap); end
        checks++; if (rise_cnt != 32) begin errors++; $display("FAIL write_at.rises got %0d want 32", rise_cnt); end
        checks++; if (r_cs !== 1'b1) begin errors++; $display("FAIL write_at.cs_at_done got %b want 1", r_cs); end
    endtask

    task automatic test_read_at();
        issue(OP_READ_AT, 20'h01234, 8'h00, 24, 8'h5A, 1'b0, 1'b0);
        checks++; if (r_seen !== 1'b1) begin errors++; $display("FAIL read_at.done got %b want 1", r_seen); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL read_at.error got %b want 0", r_err); end
        checks++; if (cap !== 32'h00601234) begin errors++; $display("FAIL read_at.frame got %h want 00601234", cap); end
        checks++; if (rise_cnt != 32) begin errors++; $display("FAIL read_at.rises got %0d want 32", rise_cnt); end
        checks++; if (r_rdata !== 8'h5A) begin errors++; $display("FAIL read_at.rd_data got %h want 5a", r_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        issue(OP_READ_AT, 20'h00000, 8'h00, 24, 8'h00, 1'b0, 1'b0);
        checks++; if (cap !== 32'h00600000) begin errors++; $display("FAIL b2b.read_at_frame got %h want 00600000", cap); end
        for (int i = 1; i <= 5; i++) begin
            want = 8'(i);
            issue(OP_READ_NEXT, 20'h00000, 8'h00, 8, want, 1'b0, 1'b0);
            checks++; if (r_seen !== 1'b1 || r_rdata !== want) begin
                errors++; $display("FAIL b2b.read_next%0d got done=%b data=%h want done=1 data=%h", i, r_seen, r_rdata, want);
            end
            checks++; if (cap !== 32'h00000020 || rise_cnt != 16) begin
                errors++; $display("FAIL b2b.frame%0d got %h/%0d want 00000020/16", i, cap, rise_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        issue(OP_WRITE_AT, 20'hFFFFF, 8'hA5, 32, 8'h00, 1'b0, 1'b0);
        checks++; if (cap !== 32'h8FFFFFA5) begin errors++; $display("FAIL wrap.frame got %h want 8fffffa5", cap); end
        issue(OP_READ_NEXT, 20'h00000, 8'h00, 8, 8'hC3, 1'b0, 1'b0);
        checks++; if (cap !== 32'h00000020) begin errors++; $display("FAIL wrap.next_frame got %h want 00000020", cap); end
        checks++; if (r_rdata !== 8'hC3) begin errors++; $display("FAIL wrap.rd_data got %h want c3", r_rdata); end
    endtask

    task automatic test_ignore_valid();
        logic cs_fell;
        issue(OP_WRITE_NEXT, 20'h00000, 8'h3C, 16, 8'h00, 1'b0, 1'b1);
        checks++; if (cap !== 32'h0000403C || rise_cnt != 16) begin
            errors++; $display("FAIL ignore.frame got %h/%0d want 0000403c/16", cap, rise_cnt);
        end
        cs_fell = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            if (!spi_cs_no) cs_fell = 1'b1;
        end
        checks++; if (cs_fell !== 1'b0) begin errors++; $display("FAIL ignore.queued got cs_fell=%b want 0", cs_fell); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL ignore.ready got %b want 1", cmd_ready_o); end
    endtask

    task automatic test_timeout();
        int dt;
        issue(OP_WRITE_AT, 20'h00010, 8'h11, 32, 8'h00, 1'b1, 1'b0);
        dt = r_cyc - fall_cyc;
        checks++; if (r_seen !== 1'b1 || r_err !== 1'b1) begin
            errors++; $display("FAIL timeout.error got done=%b err=%b want 1/1", r_seen, r_err);
        end
        checks++; if (r_cs !== 1'b1) begin errors++; $display("FAIL timeout.cs_at_done got %b want 1", r_cs); end
        checks++; if (dt < 62 || dt > 76) begin errors++; $display("FAIL timeout.latency got %0d want 62..76", dt); end
        issue(OP_READ_NEXT, 20'h00000, 8'h00, 8, 8'h99, 1'b0, 1'b0);
        checks++; if (r_err !== 1'b0 || r_rdata !== 8'h99) begin
            errors++; $display("FAIL timeout.recover got err=%b data=%h want 0/99", r_err, r_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        logic saw_done;
        n = 0;
        while (!cmd_ready_o && n < 200) begin @(negedge clock_i); n++; end
        tgt_bits = 32; tgt_resp = 8'h00; tgt_hang = 1'b0;
        cmd_op_i = OP_WRITE_AT; cmd_addr_i = 20'h00000; cmd_data_i = 8'h55; cmd_valid_i = 1'b1;
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        n = 0;
        while (rise_cnt < 10 && n < 1000) begin @(negedge clock_i); n++; end
        checks++; if (rise_cnt < 10) begin errors++; $display("FAIL reset_mid.reach_byte2 got %0d rises want >=10", rise_cnt); end
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        checks++; if (spi_cs_no !== 1'b1 || spi_sck_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid.cs_sck got cs=%b sck=%b want 1/0", spi_cs_no, spi_sck_o);
        end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_mid.rd_data got %h want 00", rd_data_o); end
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock_i);
            if (done_o) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_mid.no_done got %b want 0", saw_done); end
        issue(OP_WRITE_AT, 20'h12345, 8'h77, 32, 8'h00, 1'b0, 1'b0);
        checks++; if (r_seen !== 1'b1 || r_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid.after got done=%b err=%b want 1/0", r_seen, r_err);
        end
        checks++; if (cap !== 32'h81234577) begin errors++; $display("FAIL reset_mid.frame got %h want 81234577", cap); end
    endtask

    initial begin
        test_reset();
        test_write_at();
        test_read_at();
        test_back_to_back();
        test_wrap();
        test_ignore_valid();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
